// File: rtl/multicycle_control_unit.sv
// -----------------------------------------------------------------------------
// multicycle_control_unit
//
// Main sequencer for a multi-cycle RV32I core. Walks each instruction through
// IF -> ID -> EX -> (MEM) -> (WB), drives the fetch strobes and datapath
// controls, waits on the data-memory ready handshake, counts retired
// instructions, and parks in a sticky TRAP state on an illegal opcode or a
// memory timeout.
//
// Ports
//   clk, rst            rising-edge clock, synchronous active-high reset
//   opcode/funct3/funct7 decoded IR fields (stable from ID until next IF)
//   alu_zero            ALU result == 0, consulted in EX for branches
//   mem_ready           data memory handshake, sampled in MEM
//   pc_write, ir_write  fetch/decode strobes
//   pc_src              0: PC+4, 1: branch/jump target
//   reg_write           register file write enable
//   alu_src_a/b, alu_op ALU operand and operation select
//   mem_read/mem_write  data memory requests
//   wb_sel              00 ALU, 01 memory data, 10 PC+4
//   trap                sticky fault flag
//   state               current FSM state (observation)
//   instret             retired-instruction count
// -----------------------------------------------------------------------------
module multicycle_control_unit #(
  parameter int INSTRET_W   = 32,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [6:0]           opcode,
  input  logic [2:0]           funct3,
  input  logic [6:0]           funct7,
  input  logic                 alu_zero,
  input  logic                 mem_ready,
  output logic                 pc_write,
  output logic                 ir_write,
  output logic                 pc_src,
  output logic                 reg_write,
  output logic                 alu_src_a,
  output logic                 alu_src_b,
  output logic [3:0]           alu_op,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [1:0]           wb_sel,
  output logic                 trap,
  output logic [2:0]           state,
  output logic [INSTRET_W-1:0] instret
);

  typedef enum logic [2:0] {
    ST_IF   = 3'd0,
    ST_ID   = 3'd1,
    ST_EX   = 3'd2,
    ST_MEM  = 3'd3,
    ST_WB   = 3'd4,
    ST_TRAP = 3'd7
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  // Last stalled cycle allowed before the access is declared dead.
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t                state_r;
  logic [INSTRET_W-1:0]  instret_r;
  logic                  trap_r;
  logic [7:0]            wait_cnt_r;

  logic is_r_s, is_i_s, is_load_s, is_store_s, is_branch_s, is_jal_s, is_lui_s;
  logic legal_s;
  logic alu_src_a_s, alu_src_b_s;
  logic [3:0] alu_op_s;

  // Only funct7[5] selects SUB/SRA; the other bits are don't-care here.
  logic unused_funct7_s;
  assign unused_funct7_s = ^{funct7[6], funct7[4:0]};

  // Instruction class decode; only BEQ/BNE are supported branch forms.
  always_comb begin
    is_r_s      = (opcode == OP_R);
    is_i_s      = (opcode == OP_I);
    is_load_s   = (opcode == OP_LOAD);
    is_store_s  = (opcode == OP_STORE);
    is_branch_s = (opcode == OP_BRANCH) && (funct3[2:1] == 2'b00);
    is_jal_s    = (opcode == OP_JAL);
    is_lui_s    = (opcode == OP_LUI);
    legal_s     = is_r_s | is_i_s | is_load_s | is_store_s |
                  is_branch_s | is_jal_s | is_lui_s;
  end

  // ALU operand/operation select per instruction class.
  always_comb begin
    alu_src_a_s = 1'b0;
    alu_src_b_s = 1'b0;
    alu_op_s    = 4'b0000;
    if (is_r_s) begin
      alu_op_s = {funct7[5], funct3};
    end else if (is_i_s) begin
      alu_src_b_s = 1'b1;
      // Bit 3 only distinguishes SRAI from SRLI; other immediates use ADD-class.
      alu_op_s    = {((funct3 == 3'b101) ? funct7[5] : 1'b0), funct3};
    end else if (is_branch_s) begin
      alu_op_s = 4'b1000;
    end else if (is_load_s || is_store_s) begin
      alu_src_b_s = 1'b1;
    end else if (is_lui_s) begin
      // LUI computes 0 + imm32.
      alu_src_a_s = 1'b1;
      alu_src_b_s = 1'b1;
    end else begin
      alu_op_s = 4'b0000;
    end
  end

  // Sequencer: state, retire counter, sticky trap and MEM wait counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IF;
      instret_r  <= {INSTRET_W{1'b0}};
      trap_r     <= 1'b0;
      wait_cnt_r <= 8'd0;
    end else begin
      wait_cnt_r <= 8'd0;
      case (state_r)
        ST_IF: begin
          state_r <= ST_ID;
        end
        ST_ID: begin
          if (legal_s) begin
            state_r <= ST_EX;
          end else begin
            state_r <= ST_TRAP;
            trap_r  <= 1'b1;
          end
        end
        ST_EX: begin
          if (is_branch_s) begin
            instret_r <= instret_r + INSTRET_W'(1);
            state_r   <= ST_IF;
          end else if (is_load_s || is_store_s) begin
            state_r <= ST_MEM;
          end else if (is_r_s || is_i_s || is_lui_s || is_jal_s) begin
            state_r <= ST_WB;
          end else begin
            state_r <= ST_TRAP;
            trap_r  <= 1'b1;
          end
        end
        ST_MEM: begin
          if (mem_ready) begin
            if (is_load_s) begin
              state_r <= ST_WB;
            end else if (is_store_s) begin
              instret_r <= instret_r + INSTRET_W'(1);
              state_r   <= ST_IF;
            end else begin
              state_r <= ST_TRAP;
              trap_r  <= 1'b1;
            end
          end else if (wait_cnt_r == WAIT_LAST) begin
            state_r <= ST_TRAP;
            trap_r  <= 1'b1;
          end else begin
            wait_cnt_r <= wait_cnt_r + 8'd1;
          end
        end
        ST_WB: begin
          instret_r <= instret_r + INSTRET_W'(1);
          state_r   <= ST_IF;
        end
        ST_TRAP: begin
          state_r <= ST_TRAP;
          trap_r  <= 1'b1;
        end
        default: begin
          state_r <= ST_TRAP;
          trap_r  <= 1'b1;
        end
      endcase
    end
  end

  // Output decode from state and IR fields; everything held low during reset.
  always_comb begin
    pc_write  = 1'b0;
    ir_write  = 1'b0;
    pc_src    = 1'b0;
    reg_write = 1'b0;
    alu_src_a = 1'b0;
    alu_src_b = 1'b0;
    alu_op    = 4'b0000;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    wb_sel    = 2'b00;
    trap      = 1'b0;
    state     = 3'd0;
    instret   = {INSTRET_W{1'b0}};
    if (rst) begin
      trap = 1'b0;
    end else begin
      state   = state_r;
      instret = instret_r;
      trap    = trap_r;
      case (state_r)
        ST_IF: begin
          pc_write = 1'b1;
          ir_write = 1'b1;
        end
        ST_ID: begin
          pc_write = 1'b0;
        end
        ST_EX: begin
          alu_src_a = alu_src_a_s;
          alu_src_b = alu_src_b_s;
          alu_op    = alu_op_s;
          if (is_branch_s) begin
            // funct3[0] inverts the condition: BEQ takes on zero, BNE on non-zero.
            pc_write = alu_zero ^ funct3[0];
            pc_src   = 1'b1;
          end else if (is_jal_s) begin
            pc_write = 1'b1;
            pc_src   = 1'b1;
          end else begin
            pc_write = 1'b0;
          end
        end
        ST_MEM: begin
          alu_src_a = alu_src_a_s;
          alu_src_b = alu_src_b_s;
          alu_op    = alu_op_s;
          mem_read  = is_load_s;
          mem_write = is_store_s;
        end
        ST_WB: begin
          alu_src_a = alu_src_a_s;
          alu_src_b = alu_src_b_s;
          alu_op    = alu_op_s;
          reg_write = 1'b1;
          if (is_load_s) begin
            wb_sel = 2'b01;
          end else if (is_jal_s) begin
            wb_sel = 2'b10;
          end else begin
            wb_sel = 2'b00;
          end
        end
        ST_TRAP: begin
          trap = 1'b1;
        end
        default: begin
          trap = trap_r;
        end
      endcase
    end
  end

endmodule
